// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered read data, occupancy count and
// programmable almost-full/almost-empty flags. Define FIFO_ERR_EN to enable sticky overflow/underflow.
module fifo_sync_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         r_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         w_ptr;
  logic [AW-1:0]         r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags decode directly from the registered occupancy.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= data_in;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) w_ptr <= w_ptr + AW'(1);
      if (rd_acc) begin
        data_out <= mem[r_ptr];
        r_ptr    <= r_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky error flags; a same-cycle clear takes priority over a new set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
